uart_core: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_if.sv | 34 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_core.sv | 203 ++++++++++++++++++++
 tb/tb_uart_core.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the uart_core slice.
// FSM state encodings, oversampling constants, parameter defaults.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;

  localparam int DEF_DBITS    = 8;
  localparam int DEF_SB_TICK  = 16;
  localparam int DEF_BR_BITS  = 6;
  localparam int DEF_BR_LIMIT = 53;

endpackage

// File: rtl/uart_if.sv
// uart_if: byte-side handshake between uart_core and its control FSM.
// UART_FRAME_ERR_EN adds the rx_frame_err flag.
interface uart_if #(
  parameter int DBITS = 8
);
  logic [DBITS-1:0] rx_data;
  logic             rx_done;
  logic             tx_start;
  logic [DBITS-1:0] tx_data;
  logic             tx_done;
`ifdef UART_FRAME_ERR_EN
  logic             rx_frame_err;

  modport master (
    output tx_start, tx_data,
    input  rx_data, rx_done, tx_done, rx_frame_err
  );

  modport slave (
    input  tx_start, tx_data,
    output rx_data, rx_done, tx_done, rx_frame_err
  );
`else
  modport master (
    output tx_start, tx_data,
    input  rx_data, rx_done, tx_done
  );

  modport slave (
    input  tx_start, tx_data,
    output rx_data, rx_done, tx_done
  );
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: mod-BR_LIMIT counter producing the oversample tick.
// tick is high for the single cycle the count sits at BR_LIMIT-1.
module uart_baud_tick #(
  parameter int BR_BITS  = 6,
  parameter int BR_LIMIT = 53
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam logic [BR_BITS-1:0] LAST = BR_BITS'(BR_LIMIT - 1);

  logic [BR_BITS-1:0] cnt;

  // free-running count 0..BR_LIMIT-1
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1 UART, shared baud tick, 16x oversampled rx and tx.
// Define UART_FRAME_ERR_EN to flag a low stop bit on rx_frame_err.
module uart_core
  import uart_pkg::*;
#(
  parameter int DBITS    = DEF_DBITS,
  parameter int SB_TICK  = DEF_SB_TICK,
  parameter int BR_BITS  = DEF_BR_BITS,
  parameter int BR_LIMIT = DEF_BR_LIMIT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rx,
  output logic  tx,
  output logic  tick,
  uart_if.slave bus
);
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam int SW = (SB_TICK > OVERSAMPLE) ?
                      $clog2(SB_TICK) : $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S_MID  = SW'(MID_START);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBITS - 1);

  logic [1:0]       rx_sync;
  logic             rxs;

  rx_state_t        rx_st;
  logic [SW-1:0]    rs;
  logic [NW-1:0]    rn;
  logic [DBITS-1:0] rsh;
  logic             rdone;
  logic             rferr;

  tx_state_t        tx_st;
  logic [SW-1:0]    ts;
  logic [NW-1:0]    tn;
  logic [DBITS-1:0] tsh;
  logic             tx_r;
  logic             tdone;

  uart_baud_tick #(
    .BR_BITS  (BR_BITS),
    .BR_LIMIT (BR_LIMIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // two-flop synchronizer on the async serial input, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], rx};
    end
  end

  assign rxs = rx_sync[1];

  // receiver: centre on the start bit, then sample every 16 ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st <= RX_IDLE;
      rs    <= '0;
      rn    <= '0;
      rsh   <= '0;
      rdone <= 1'b0;
      rferr <= 1'b0;
    end else begin
      rdone <= 1'b0;
      rferr <= 1'b0;
      unique case (rx_st)
        RX_IDLE: begin
          if (!rxs) begin
            rs    <= '0;
            rx_st <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rs == S_MID) begin
              if (!rxs) begin
                rs    <= '0;
                rn    <= '0;
                rx_st <= RX_DATA;
              end else begin
                rx_st <= RX_IDLE;
              end
            end else begin
              rs <= rs + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rs == S_BIT) begin
              rs  <= '0;
              rsh <= {rxs, rsh[DBITS-1:1]};
              if (rn == N_LAST) begin
                rx_st <= RX_STOP;
              end else begin
                rn <= rn + 1'b1;
              end
            end else begin
              rs <= rs + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rs == S_STOP) begin
              rdone <= 1'b1;
              rferr <= !rxs;
              rx_st <= RX_IDLE;
            end else begin
              rs <= rs + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // transmitter: tx is registered and set on each state transition
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= TX_IDLE;
      ts    <= '0;
      tn    <= '0;
      tsh   <= '0;
      tx_r  <= 1'b1;
      tdone <= 1'b0;
    end else begin
      tdone <= 1'b0;
      unique case (tx_st)
        TX_IDLE: begin
          tx_r <= 1'b1;
          if (bus.tx_start) begin
            tsh   <= bus.tx_data;
            ts    <= '0;
            tx_r  <= 1'b0;
            tx_st <= TX_START;
          end
        end
        TX_START: begin
          if (tick) begin
            if (ts == S_BIT) begin
              ts    <= '0;
              tn    <= '0;
              tx_r  <= tsh[0];
              tx_st <= TX_DATA;
            end else begin
              ts <= ts + 1'b1;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (ts == S_BIT) begin
              ts  <= '0;
              tsh <= tsh >> 1;
              if (tn == N_LAST) begin
                tx_r  <= 1'b1;
                tx_st <= TX_STOP;
              end else begin
                tn   <= tn + 1'b1;
                tx_r <= tsh[1];
              end
            end else begin
              ts <= ts + 1'b1;
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (ts == S_STOP) begin
              tdone <= 1'b1;
              tx_st <= TX_IDLE;
            end else begin
              ts <= ts + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign tx          = tx_r;
  assign bus.rx_data = rsh;
  assign bus.rx_done = rdone;
  assign bus.tx_done = tdone;
`ifdef UART_FRAME_ERR_EN
  assign bus.rx_frame_err = rferr;
`else
  logic unused_ferr;
  assign unused_ferr = rferr;
`endif

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: self-checking bench for uart_core (table + scoreboard).
// Honours UART_FRAME_ERR_EN when the design is built with it.
`timescale 1ns/1ps
module tb_uart_core;
  import uart_pkg::*;

  localparam int BIT = 16 * DEF_BR_LIMIT;

  typedef struct {
    logic [7:0] d;
    logic       sb;
  } rx_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_drv = 1'b1;
  logic loopback = 1'b0;
  logic rx;
  logic tx;
  logic tick;

  int n_vec = 0;
  int n_err = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  bit tx_mon = 1'b1;

  logic [8:0] rx_q[$];
  logic [7:0] tx_q[$];
  rx_vec_t    tbl[4];

  logic [7:0] m_d;
  logic [7:0] m_e;
  logic       m_st;
  logic       m_sb;

  always #5 clk = ~clk;

  uart_if #(.DBITS(DEF_DBITS)) bus();

  assign rx = loopback ? tx : rx_drv;

  uart_core #(
    .DBITS    (DEF_DBITS),
    .SB_TICK  (DEF_SB_TICK),
    .BR_BITS  (DEF_BR_BITS),
    .BR_LIMIT (DEF_BR_LIMIT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .tx   (tx),
    .tick (tick),
    .bus  (bus)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // rx scoreboard: every rx_done pops one expected byte
  always @(negedge clk) begin
    if (!rst && bus.rx_done) begin
      logic [8:0] e;
      rx_cnt++;
      if (rx_q.size() == 0) begin
        chk("rx_spurious_done", 32'(bus.rx_done), 32'd0);
      end else begin
        e = rx_q.pop_front();
        chk("rx_data", 32'(bus.rx_data), 32'(e[7:0]));
`ifdef UART_FRAME_ERR_EN
        chk("rx_frame_err", 32'(bus.rx_frame_err), 32'(e[8]));
`endif
      end
    end
`ifdef UART_FRAME_ERR_EN
    if (!rst && bus.rx_frame_err && !bus.rx_done)
      chk("ferr_stray", 32'(bus.rx_frame_err), 32'd0);
`endif
  end

  // count tx_done pulses
  always @(negedge clk) begin
    if (!rst && bus.tx_done) tx_cnt++;
  end

  // tx line decoder: samples mid-bit, pops the expected byte
  initial begin
    forever begin
      @(negedge clk);
      if (tx_mon && !rst && tx === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        m_st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          m_d[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        m_sb = tx;
        if (tx_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_spurious_frame: got %h want none", m_d);
        end else begin
          m_e = tx_q.pop_front();
          chk("tx_frame", 32'({m_st, m_d, m_sb}),
              32'({1'b0, m_e, 1'b1}));
        end
      end
    end
  end

  task automatic send_rx(logic [7:0] d, logic sb);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx_drv = sb;
    repeat (sb ? BIT : 600) @(negedge clk);
    rx_drv = 1'b1;
    repeat (sb ? 200 : 900) @(negedge clk);
  endtask

  task automatic wait_rx(int n, int lim);
    int t = 0;
    while (rx_cnt < n && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (rx_cnt < n) chk("rx_wait_timeout", 32'(rx_cnt), 32'(n));
  endtask

  task automatic wait_txd(output int t);
    t = 0;
    while (!bus.tx_done && t < 9000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.tx_done) chk("tx_done_timeout", 32'(bus.tx_done), 32'd1);
  endtask

  task automatic send_tx(logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  initial begin
    int tix[3];
    int k;
    int nt;
    int t;
    int rc;
    int tc;
    logic fe;

    tbl[0] = '{d: 8'hA5, sb: 1'b1};
    tbl[1] = '{d: 8'h81, sb: 1'b1};
    tbl[2] = '{d: 8'h55, sb: 1'b0};
    tbl[3] = '{d: 8'hC3, sb: 1'b1};

    bus.tx_start = 1'b0;
    bus.tx_data  = '0;

    repeat (4) @(negedge clk);
    chk("rst_tick",    32'(tick),        32'd0);
    chk("rst_rx_done", 32'(bus.rx_done), 32'd0);
    chk("rst_tx_done", 32'(bus.tx_done), 32'd0);
    chk("rst_tx",      32'(tx),          32'd1);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);

    rst = 1'b0;
    k  = 0;
    nt = 0;
    for (int i = 0; i <= 170; i++) begin
      if (tick) begin
        if (k < 3) tix[k] = i;
        k++;
        nt++;
      end
      @(negedge clk);
    end
    for (int j = 0; j < 3; j++)
      chk("baud_tick_at", 32'(tix[j]), 32'(52 + 53 * j));
    chk("baud_tick_count", 32'(nt), 32'd3);

    fork
      begin
        for (int i = 0; i < 4; i++) begin
`ifdef UART_FRAME_ERR_EN
          fe = ~tbl[i].sb;
`else
          fe = 1'b0;
`endif
          rx_q.push_back({fe, tbl[i].d});
          send_rx(tbl[i].d, tbl[i].sb);
          wait_rx(i + 1, 2000);
        end
        rx_drv = 1'b0;
        repeat (200) @(negedge clk);
        rx_drv = 1'b1;
        repeat (700) @(negedge clk);
        chk("glitch_no_done", 32'(rx_cnt), 32'd4);
        rx_q.push_back({1'b0, 8'h3C});
        send_rx(8'h3C, 1'b1);
        wait_rx(5, 2000);
      end
      begin
        tx_q.push_back(8'h5A);
        send_tx(8'h5A);
        wait_txd(t);
        chk("tx_done_latency",
            32'(t >= 8428 && t <= 8480), 32'd1);
        repeat (100) @(negedge clk);

        tx_q.push_back(8'h01);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h03);
        bus.tx_data  = 8'h01;
        bus.tx_start = 1'b1;
        @(negedge clk);
        wait_txd(t);
        bus.tx_data = 8'h02;
        @(negedge clk);
        chk("stream_gap_1", 32'(tx), 32'd0);
        wait_txd(t);
        bus.tx_data = 8'h03;
        @(negedge clk);
        chk("stream_gap_2", 32'(tx), 32'd0);
        bus.tx_start = 1'b0;
        wait_txd(t);
        @(negedge clk);
        chk("tx_done_count", 32'(tx_cnt), 32'd4);
      end
    join

    repeat (BIT) @(negedge clk);
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);

    loopback = 1'b1;
    repeat (20) @(negedge clk);
    tx_q.push_back(8'hFF);
    rx_q.push_back({1'b0, 8'hFF});
    send_tx(8'hFF);
    wait_rx(6, 9000);
    wait_txd(t);
    repeat (100) @(negedge clk);
    tx_q.push_back(8'h00);
    rx_q.push_back({1'b0, 8'h00});
    send_tx(8'h00);
    wait_rx(7, 9000);
    wait_txd(t);
    repeat (BIT) @(negedge clk);
    chk("loop_tx_done_count", 32'(tx_cnt), 32'd6);

    tx_mon = 1'b0;
    send_tx(8'h96);
    repeat (3000) @(negedge clk);
    rc  = rx_cnt;
    tc  = tx_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx_high", 32'(tx), 32'd1);
    chk("rst_mid_rx_done", 32'(bus.rx_done), 32'd0);
    rst = 1'b0;
    repeat (6000) @(negedge clk);
    chk("abort_no_rx_done", 32'(rx_cnt), 32'(rc));
    chk("abort_no_tx_done", 32'(tx_cnt), 32'(tc));
    chk("abort_tx_idle", 32'(tx), 32'd1);
    tx_mon = 1'b1;

    chk("rx_q_drained", 32'(rx_q.size()), 32'd0);
    chk("tx_q_empty", 32'(tx_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
